inner_function_accumulator: RTL and testbench
=============================================

Name: inner_function_accumulator

Overview:
- Downstream consumer of the inner_function pipeline. Takes the stream of 32-bit IEEE-754 single results, one per done pulse, and produces their floating-point sum for one job.
- Uses one fp_addsub_custom instance (FP_ADD_LATENCY cycles, fully pipelined) with FP_ADD_LATENCY partial sums circulating in its pipeline.
- After the last input it collects the partial sums, reduces them serially, and presents the sum with a one-cycle done pulse (custom-instruction style).

Parameters:
- FP_ADD_LATENCY, 11, latency of fp_addsub_custom in cycles; also the number of circulating partial sums.
- FP_ZERO, 32'h00000000, +0.0 used as the neutral operand.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- clk_en  in  1  global enable; when low, all registers and the adder hold.
- start  in  1  one-cycle pulse; begins a new job (accepted only in IDLE or DONE).
- in_valid  in  1  inner_function done, one pulse per item.
- in_data  in  32  inner_function result (float).
- in_last  in  1  qualified by in_valid; marks the final item of the job.
- in_ready  out  1  high only in ACCUM.
- busy  out  1  high in ACCUM, COLLECT, REDUCE.
- sum  out  32  final sum; stable from done until the next start.
- done  out  1  one-cycle pulse when sum is valid.

Behaviour:
- Reset (reset_n=0 at a clock edge, regardless of clk_en): state=IDLE; sum=0; done=0; in_ready=0; busy=0; live-mask and counters cleared. Stale data in the adder pipeline is masked out and never enters a later sum.
- States:
  - IDLE: start -> ACCUM.
  - ACCUM: in_ready=1 -> COLLECT on the cycle after accepting in_valid&in_last.
  - COLLECT: exactly FP_ADD_LATENCY cycles -> REDUCE.
  - REDUCE -> DONE after FP_ADD_LATENCY-1 serial adds.
  - DONE: done=1 for this single cycle -> IDLE. start in DONE -> ACCUM (done still pulses).
- ACCUM datapath, every enabled cycle:
  - Adder a = in_valid ? in_data : FP_ZERO.
  - Adder b = live[out] ? adder_result : FP_ZERO.
  - live is an FP_ADD_LATENCY-bit shift register tracking which pipeline slot carries a live partial sum. Issuing in ACCUM shifts in 1; entering ACCUM clears all bits.
- in_valid outside ACCUM is ignored (not summed, no error). start outside IDLE/DONE is ignored.
- COLLECT: adder issues a=b=FP_ZERO. Each cycle, pbuf[k] = live[out] ? adder_result : FP_ZERO, for k=0..FP_ADD_LATENCY-1.
- REDUCE:
  - acc=pbuf[0].
  - For i=1..FP_ADD_LATENCY-1: issue add(acc,pbuf[i]) once, wait FP_ADD_LATENCY cycles, latch acc=result. Each step takes FP_ADD_LATENCY+1 cycles.
  - The add order is fixed, so results are bit-exact and reproducible.
- Latency, last accepted item (cycle t) -> done:
  - t + FP_ADD_LATENCY + (FP_ADD_LATENCY-1)*(FP_ADD_LATENCY+1) + 1.
  - That is 132 cycles for L=11.
  - Latency is independent of item count and input gaps.
- sum updates only on entry to DONE.
- clk_en=0 freezes the state, counters, live mask, and adder together. Latency is counted in enabled cycles only.
- A job with a single item returns that item exactly. -0.0 inputs sum to +0.0.
- No overflow handling beyond IEEE behaviour of the adder (inf/NaN propagate).

Decomposition:
- Shared package inner_function_pkg holds: FP_ADD_LATENCY, FP_MULT_LATENCY, CORDIC_LATENCY, FP_ZERO, FP_ONE, and the state encoding (IDLE/ACCUM/COLLECT/REDUCE/DONE).
- No new sub-module: fp_addsub_custom is instanced as-is, with add_sub tied for add and its clk_en driven from clk_en.
- pbuf, the live mask, and the FSM stay in this module.

Test Plan:
- start; 20 × in_data=0x3F800000 (1.0) back-to-back, last on #20 -> done 132 cycles after #20; sum=0x41A00000 (20.0).
- start; a single item 0x40200000 (2.5) with last -> sum=0x40200000; busy high from start until done.
- start; items 1.0..11.0 with random 0–5 cycle gaps in in_valid -> sum=0x42840000 (66.0); latency still 132 from last.
- Mid-job, clk_en low for 7 cycles (including a cycle with in_valid high during the freeze) -> that input is ignored; done arrives 7 cycles later than nominal; sum excludes the ignored item.
- reset_n low one cycle mid-ACCUM after 5 × 3.0, then a new job of 3 × 1.0 -> sum=0x40400000 (3.0), so stale pipeline data is masked; done/in_ready/busy were 0 immediately after reset.
- in_valid pulses while IDLE and during REDUCE, plus start during COLLECT -> all ignored; sum unchanged; a single done pulse for the active job.

Source files
------------

// File: rtl/inner_function_pkg.sv
// Shared constants and state encoding for the inner_function pipeline blocks.
package inner_function_pkg;

    localparam int FP_ADD_LATENCY  = 11;
    localparam int FP_MULT_LATENCY = 5;
    localparam int CORDIC_LATENCY  = 16;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    // Accumulator job states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_REDUCE  = 3'd3,
        ST_DONE    = 3'd4
    } acc_state_t;

endpackage

// File: rtl/inner_function_accumulator_if.sv
// Job/stream interface between the inner_function pipeline and its accumulator.
//
// Handshake: in_valid is a one-cycle "item done" pulse from the producer.
// An item is consumed on a clock edge where in_valid && in_ready && clk_en;
// the producer never stalls on in_ready, so items offered while in_ready is
// low are simply dropped. in_last is only meaningful together with in_valid.
// start is a one-cycle pulse; done is a one-cycle pulse with sum valid and
// held until the next accepted start.
interface inner_function_accumulator_if;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        busy;
    logic [31:0] sum;
    logic        done;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, busy, sum, done
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, busy, sum, done
    );
endinterface

// File: rtl/fp_addsub_custom.sv
// Fully pipelined IEEE-754 single add/subtract, round-to-nearest-even.
// add_sub = 1 adds, 0 subtracts. Data pipeline has no reset.
module fp_addsub_custom #(
    parameter int LATENCY = 11
) (
    input  logic        clock,
    input  logic        clk_en,
    input  logic        add_sub,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] pipe [LATENCY];

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q;
        logic [7:0]  ep, eq, d;
        logic [26:0] ap, aq, aq_sh;
        logic [27:0] s;
        logic [9:0]  er;
        logic [24:0] mr;
        logic        up;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0))
                return QNAN;
            if (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31])
                return QNAN;
            return (x[30:23] == 8'hFF) ? x : y;
        end
        // p carries the larger magnitude so the difference is never negative
        if (x[30:0] < y[30:0]) begin
            p = y;
            q = x;
        end else begin
            p = x;
            q = y;
        end
        ep = (p[30:23] == 8'd0) ? 8'd1 : p[30:23];
        eq = (q[30:23] == 8'd0) ? 8'd1 : q[30:23];
        d  = ep - eq;
        ap = {p[30:23] != 8'd0, p[22:0], 3'b000};
        aq = {q[30:23] != 8'd0, q[22:0], 3'b000};
        if (d >= 8'd27) begin
            aq_sh = {26'd0, aq != 27'd0};
        end else begin
            aq_sh    = aq >> d;
            aq_sh[0] = aq_sh[0] | ((aq & ((27'd1 << d) - 27'd1)) != 27'd0);
        end
        if (p[31] == q[31]) s = {1'b0, ap} + {1'b0, aq_sh};
        else                s = {1'b0, ap} - {1'b0, aq_sh};
        // exact cancellation gives +0; only -0 + -0 keeps the sign
        if (s == 28'd0) return (p[31] == q[31]) ? {p[31], 31'd0} : 32'd0;
        er = {2'b00, ep};
        if (s[27]) begin
            s  = {1'b0, s[27:2], s[1] | s[0]};
            er = er + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && er > 10'd1) begin
                    s  = s << 1;
                    er = er - 10'd1;
                end
            end
        end
        up = s[2] & (s[3] | s[1] | s[0]);
        mr = {1'b0, s[26:3]} + {24'd0, up};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            er = er + 10'd1;
        end
        if (er >= 10'd255) return {p[31], 8'hFF, 23'd0};
        return {p[31], mr[23] ? er[7:0] : 8'h00, mr[22:0]};
    endfunction

    // Compute in stage 0, then delay through the remaining stages
    always_ff @(posedge clock) begin
        if (clk_en) begin
            pipe[0] <= fp_add(dataa, add_sub ? datab : {~datab[31], datab[30:0]});
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LATENCY-1];

endmodule

// File: rtl/inner_function_accumulator.sv
// Sums one job of float results using FP_ADD_LATENCY partial sums that
// circulate through a single pipelined adder, then reduces them serially
// in a fixed order so the result is bit-reproducible.
module inner_function_accumulator
    import inner_function_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          clk_en,
    inner_function_accumulator_if.slave   acc_if,
    output acc_state_t                    dbg_state
);
    localparam int L  = FP_ADD_LATENCY;
    localparam int CW = $clog2(L + 1);

    acc_state_t  state, state_nx;
    logic [L-1:0]  live;        // live[L-1] marks the slot now at the adder output
    logic [CW-1:0] cnt;         // COLLECT slot index, REDUCE wait phase
    logic [CW-1:0] step;        // REDUCE: index of pbuf being added
    logic [31:0]   pbuf [L];
    logic [31:0]   acc, sum_q, add_a, add_b, add_res;
    logic          live_out, collect_end, reduce_end;

    assign live_out    = live[L-1];
    assign collect_end = (state == ST_COLLECT) && (cnt == CW'(L - 1));
    assign reduce_end  = (state == ST_REDUCE) && (step == CW'(L - 1)) && (cnt == CW'(L));

    // State register: reset wins over clk_en, otherwise hold when disabled
    always_ff @(posedge clock) begin
        if (!reset_n)    state <= ST_IDLE;
        else if (clk_en) state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (acc_if.start) state_nx = ST_ACCUM;
            ST_ACCUM:   if (acc_if.in_valid && acc_if.in_last) state_nx = ST_COLLECT;
            ST_COLLECT: if (collect_end) state_nx = ST_REDUCE;
            ST_REDUCE:  if (reduce_end) state_nx = ST_DONE;
            ST_DONE:    state_nx = acc_if.start ? ST_ACCUM : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        acc_if.in_ready = (state == ST_ACCUM);
        acc_if.busy     = (state == ST_ACCUM) || (state == ST_COLLECT) || (state == ST_REDUCE);
        acc_if.done     = (state == ST_DONE);
        dbg_state       = state;
    end

    // Adder operand select: circulate partials in ACCUM, drain with zeros in
    // COLLECT, one issue per serial step in REDUCE
    always_comb begin
        add_a = FP_ZERO;
        add_b = FP_ZERO;
        case (state)
            ST_ACCUM: begin
                add_a = acc_if.in_valid ? acc_if.in_data : FP_ZERO;
                add_b = live_out ? add_res : FP_ZERO;
            end
            ST_REDUCE: begin
                if (cnt == '0) begin
                    add_a = acc;
                    add_b = pbuf[step];
                end
            end
            default: ;
        endcase
    end

    // Live mask, counters, reduction accumulator and the published sum
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            live  <= '0;
            cnt   <= '0;
            step  <= '0;
            acc   <= FP_ZERO;
            sum_q <= FP_ZERO;
        end else if (clk_en) begin
            if (state_nx == ST_ACCUM && state != ST_ACCUM) live <= '0;
            else live <= {live[L-2:0], state == ST_ACCUM};
            case (state)
                ST_COLLECT: begin
                    cnt <= collect_end ? '0 : cnt + CW'(1);
                    if (collect_end) begin
                        acc  <= pbuf[0];
                        step <= CW'(1);
                    end
                end
                ST_REDUCE: begin
                    if (cnt == CW'(L)) begin
                        cnt  <= '0;
                        step <= step + CW'(1);
                        acc  <= add_res;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    if (reduce_end) sum_q <= add_res;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Capture each slot as it leaves the adder; dead slots read as +0
    always_ff @(posedge clock) begin
        if (reset_n && clk_en && state == ST_COLLECT) pbuf[cnt] <= live_out ? add_res : FP_ZERO;
    end

    assign acc_if.sum = sum_q;

    fp_addsub_custom #(.LATENCY(L)) u_add (
        .clock   (clock),
        .clk_en  (clk_en),
        .add_sub (1'b1),
        .dataa   (add_a),
        .datab   (add_b),
        .result  (add_res)
    );

endmodule

// File: tb/tb_inner_function_accumulator.sv
// Bench for inner_function_accumulator: vector table, hand sequences for
// freeze/reset/ignored events, and random integer-valued jobs.
module tb_inner_function_accumulator;
    import inner_function_pkg::*;

    // Edges from the edge accepting the last item to the edge before done
    localparam int LAT_EDGES = FP_ADD_LATENCY + (FP_ADD_LATENCY - 1) * (FP_ADD_LATENCY + 1);

    typedef struct {
        int          n;
        logic [31:0] val;
        int          gap_max;
        logic [31:0] exp_sum;
    } vec_t;

    logic clock, reset_n, clk_en;
    acc_state_t dbg_state;
    inner_function_accumulator_if acc_if ();

    inner_function_accumulator dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .acc_if    (acc_if),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad = 0;
    int en_edges = 0;
    int wall_edges = 0;
    int done_cnt = 0;
    int busy_low = 0;
    bit trk = 0;
    int last_en = 0;
    int last_wall = 0;
    logic [31:0] exp_q[$];
    logic [31:0] item_q[$];
    vec_t vecs [8];

    // clock / edge counters / done monitor
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        wall_edges++;
        if (clk_en) en_edges++;
    end

    always @(negedge clock) if (acc_if.done) done_cnt++;

    function automatic logic [31:0] int_to_fp(input int unsigned n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        m = n << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        if (trk && !acc_if.busy && !acc_if.done) busy_low++;
    endtask

    task automatic send_item(input logic [31:0] d, input bit last, input int gap);
        acc_if.in_valid = 1'b1;
        acc_if.in_data  = d;
        acc_if.in_last  = last;
        if (last) begin
            last_en   = en_edges + 1;
            last_wall = wall_edges + 1;
        end
        cycle();
        acc_if.in_valid = 1'b0;
        acc_if.in_last  = 1'b0;
        acc_if.in_data  = '0;
        repeat (gap) cycle();
    endtask

    task automatic do_start();
        acc_if.start = 1'b1;
        cycle();
        acc_if.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (acc_if.done) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: done not seen within 400 cycles", name);
        end
    endtask

    task automatic run_queue(input string name, input int gap_max);
        bit ok;
        int d0;
        logic [31:0] exp_sum;
        d0 = done_cnt;
        busy_low = 0;
        trk = 1'b1;
        do_start();
        for (int i = 0; i < item_q.size(); i++)
            send_item(item_q[i], i == item_q.size() - 1, $urandom_range(0, gap_max));
        wait_done(name, ok);
        trk = 1'b0;
        exp_sum = exp_q.pop_front();
        if (ok) begin
            check({name, "_sum"}, acc_if.sum, exp_sum);
            check({name, "_lat"}, 32'(en_edges - last_en), 32'(LAT_EDGES));
        end
        cycle();
        cycle();
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_busy_gaps"}, 32'(busy_low), 32'd0);
    endtask

    initial begin
        bit ok;
        int d0;
        int tot;
        int n;
        int v;

        vecs[0] = '{20, 32'h3F80_0000, 0, 32'h41A0_0000};  // 20 x 1.0
        vecs[1] = '{1,  32'h4020_0000, 0, 32'h4020_0000};  // single 2.5
        vecs[2] = '{3,  32'h4040_0000, 2, 32'h4110_0000};  // 3 x 3.0
        vecs[3] = '{4,  32'hBF00_0000, 1, 32'hC000_0000};  // 4 x -0.5
        vecs[4] = '{2,  32'h8000_0000, 0, 32'h0000_0000};  // -0.0 -> +0.0
        vecs[5] = '{12, 32'h3F80_0000, 0, 32'h4140_0000};  // more items than slots
        vecs[6] = '{30, 32'h4000_0000, 3, 32'h4270_0000};  // 30 x 2.0
        vecs[7] = '{1,  32'h7F80_0000, 0, 32'h7F80_0000};  // +inf propagates

        // reset with clk_en low
        reset_n = 1'b0;
        clk_en = 1'b0;
        acc_if.start = 1'b0;
        acc_if.in_valid = 1'b0;
        acc_if.in_data = '0;
        acc_if.in_last = 1'b0;
        repeat (3) cycle();
        check("rst_done", {31'd0, acc_if.done}, 32'd0);
        check("rst_in_ready", {31'd0, acc_if.in_ready}, 32'd0);
        check("rst_busy", {31'd0, acc_if.busy}, 32'd0);
        check("rst_sum", acc_if.sum, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        clk_en = 1'b1;
        cycle();

        // vector table
        for (int i = 0; i < 8; i++) begin
            item_q.delete();
            repeat (vecs[i].n) item_q.push_back(vecs[i].val);
            exp_q.push_back(vecs[i].exp_sum);
            run_queue($sformatf("vec%0d", i), vecs[i].gap_max);
        end

        // 1.0 .. 11.0 with gaps up to 5
        item_q.delete();
        for (int i = 1; i <= 11; i++) item_q.push_back(int_to_fp(i));
        exp_q.push_back(32'h4284_0000);
        run_queue("ramp", 5);

        // clk_en freeze mid-ACCUM (with an input during it) and during REDUCE
        do_start();
        repeat (3) send_item(FP_ONE, 1'b0, 0);
        clk_en = 1'b0;
        repeat (3) cycle();
        acc_if.in_valid = 1'b1;
        acc_if.in_data = 32'h42C8_0000;
        cycle();
        acc_if.in_valid = 1'b0;
        acc_if.in_data = '0;
        repeat (3) cycle();
        clk_en = 1'b1;
        send_item(FP_ONE, 1'b0, 0);
        send_item(FP_ONE, 1'b0, 1);
        send_item(FP_ONE, 1'b1, 0);
        repeat (20) cycle();
        clk_en = 1'b0;
        repeat (7) cycle();
        clk_en = 1'b1;
        wait_done("freeze", ok);
        if (ok) begin
            check("freeze_sum", acc_if.sum, 32'h40C0_0000);
            check("freeze_lat_en", 32'(en_edges - last_en), 32'(LAT_EDGES));
            check("freeze_lat_wall", 32'(wall_edges - last_wall), 32'(LAT_EDGES + 7));
        end
        cycle();

        // reset mid-ACCUM, then a fresh job must not see stale partials
        do_start();
        repeat (5) send_item(32'h4040_0000, 1'b0, 0);
        reset_n = 1'b0;
        cycle();
        check("midrst_done", {31'd0, acc_if.done}, 32'd0);
        check("midrst_in_ready", {31'd0, acc_if.in_ready}, 32'd0);
        check("midrst_busy", {31'd0, acc_if.busy}, 32'd0);
        check("midrst_sum", acc_if.sum, 32'd0);
        reset_n = 1'b1;
        item_q.delete();
        repeat (3) item_q.push_back(FP_ONE);
        exp_q.push_back(32'h4040_0000);
        run_queue("after_reset", 0);

        // in_valid in IDLE / REDUCE and start in COLLECT are ignored
        d0 = done_cnt;
        acc_if.in_valid = 1'b1;
        acc_if.in_last = 1'b1;
        acc_if.in_data = 32'h4248_0000;
        cycle();
        acc_if.in_valid = 1'b0;
        acc_if.in_last = 1'b0;
        cycle();
        check("ign_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        do_start();
        send_item(32'h4080_0000, 1'b0, 0);
        send_item(32'h4080_0000, 1'b1, 0);
        repeat (2) cycle();
        acc_if.start = 1'b1;
        acc_if.in_valid = 1'b1;
        acc_if.in_data = 32'h4248_0000;
        cycle();
        acc_if.start = 1'b0;
        acc_if.in_valid = 1'b0;
        repeat (30) cycle();
        acc_if.in_valid = 1'b1;
        acc_if.in_last = 1'b1;
        cycle();
        acc_if.in_valid = 1'b0;
        acc_if.in_last = 1'b0;
        acc_if.in_data = '0;
        wait_done("ignore", ok);
        if (ok) begin
            check("ignore_sum", acc_if.sum, 32'h4100_0000);
            check("ignore_lat", 32'(en_edges - last_en), 32'(LAT_EDGES));
        end
        repeat (150) cycle();
        check("ignore_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("ignore_sum_hold", acc_if.sum, 32'h4100_0000);
        check("ignore_end_state", 32'(dbg_state), 32'(ST_IDLE));

        // start accepted in the DONE cycle chains straight into a new job
        do_start();
        send_item(FP_ONE, 1'b1, 0);
        wait_done("chain1", ok);
        if (ok) begin
            check("chain1_sum", acc_if.sum, FP_ONE);
            acc_if.start = 1'b1;
            cycle();
            acc_if.start = 1'b0;
            check("start_in_done", 32'(dbg_state), 32'(ST_ACCUM));
            send_item(FP_ONE, 1'b0, 0);
            send_item(FP_ONE, 1'b1, 0);
            wait_done("chain2", ok);
            if (ok) begin
                check("chain2_sum", acc_if.sum, 32'h4000_0000);
                check("chain2_lat", 32'(en_edges - last_en), 32'(LAT_EDGES));
            end
        end
        repeat (2) cycle();

        // random integer-valued jobs: every partial sum is exact, so the
        // reference is the plain integer total
        for (int j = 0; j < 6; j++) begin
            item_q.delete();
            tot = 0;
            n = $urandom_range(1, 25);
            for (int i = 0; i < n; i++) begin
                v = $urandom_range(0, 1000);
                tot += v;
                item_q.push_back(int_to_fp(v));
            end
            exp_q.push_back(int_to_fp(tot));
            run_queue($sformatf("rand%0d", j), 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
